im_loader: RTL and testbench

Writer side of the 4 KB instruction memory. It accepts a program as a byte stream over a valid/ready handshake and packs every 4 bytes into a big-endian 32-bit word. Each word is written to consecutive word addresses, starting at word 0. It sits between the host/UART byte source and the write port of the instruction RAM, and holds the CPU off (busy) until the load completes.

---
 rtl/im_loader.sv | 129 ++++++++++++
 tb/tb_im_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// Instruction-memory loader: packs a valid/ready byte stream into big-endian 32-bit words
// and writes them to consecutive word addresses from 0, holding busy until the load ends.
module im_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_din,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] MaxLen = (ADDR_W+1)'(MAX_WORDS);

  typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [1:0]        idx_q, idx_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [ADDR_W:0]   len_clamp;
  logic [ADDR_W:0]   cnt_inc;

  assign len_clamp = (len_words > MaxLen) ? MaxLen : len_words;
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    din_d      = din_q;
    idx_d      = idx_q;
    done_d     = done_q;
    byte_ready = 1'b0;
    busy       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = len_clamp;
          done_d  = 1'b0;
          cnt_d   = '0;
          addr_d  = '0;
          idx_d   = '0;
          state_d = (len_clamp == '0) ? StDone : StRecv;
        end
      end
      StRecv: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          // First byte of a word lands in the most significant lane.
          unique case (idx_q)
            2'd0: din_d[31:24] = byte_in;
            2'd1: din_d[23:16] = byte_in;
            2'd2: din_d[15:8]  = byte_in;
            2'd3: din_d[7:0]   = byte_in;
            default: ;
          endcase
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        busy  = 1'b1;
        cnt_d = cnt_inc;
        idx_d = '0;
        if (cnt_inc == len_q) begin
          state_d = StDone;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StRecv;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    we_d = (state_d == StWrite);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      we_q    <= we_d;
    end
  end

  assign im_we      = we_q;
  assign im_addr    = addr_q;
  assign im_din     = din_q;
  assign done       = done_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: expected writes are queued as words are streamed in
// and compared against the writes captured from the memory port.
module tb_im_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   len_words;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_din;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   word_count;

  im_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(1024)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len_words  (len_words),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_din     (im_din),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [41:0] exp_q[$];
  logic [41:0] obs_q[$];
  int          rd_obs   = 0;
  int          we_bad   = 0;
  int          rdy_cnt  = 0;

  // Capture every write strobe; byte_ready must be low and busy high while writing.
  always @(negedge clk) begin
    if (!rst && im_we) begin
      obs_q.push_back({im_addr, im_din});
      if (byte_ready || !busy) we_bad++;
    end
    if (byte_ready) rdy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [ADDR_W:0] n);
    @(negedge clk);
    start     = 1'b1;
    len_words = n;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input logic [ADDR_W-1:0] a);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
    exp_q.push_back({a, w});
  endtask

  task automatic wait_done(input int max_cycles);
    int t = 0;
    while (!done && t < max_cycles) begin
      @(negedge clk);
      t++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    logic [41:0] e;
    logic [41:0] o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_obs < obs_q.size()) begin
        o = obs_q[rd_obs];
        check("we_addr", {22'd0, o[41:32]}, {22'd0, e[41:32]});
        check("we_data", o[31:0], e[31:0]);
        rd_obs++;
      end else begin
        check("we_missing", 32'd0, 32'd1);
      end
    end
    check("we_extra", 32'(obs_q.size() - rd_obs), 32'd0);
    rd_obs = obs_q.size();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_we"},    {31'd0, im_we}, 32'd0);
    check({tag, "_addr"},  {22'd0, im_addr}, 32'd0);
    check({tag, "_din"},   im_din, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_count"}, {21'd0, word_count}, 32'd0);
  endtask

  initial begin
    int          n_base;
    int          r_base;
    logic [41:0] last;
    logic [31:0] w1;

    rst        = 1'b1;
    start      = 1'b0;
    len_words  = '0;
    byte_in    = '0;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Two words at full stream rate.
    n_base = obs_q.size();
    do_start(11'd2);
    send_word(32'h20080005, 0, 10'd0);
    send_word(32'hAC010000, 0, 10'd1);
    wait_done(50);
    check("t1_done",  {31'd0, done}, 32'd1);
    check("t1_busy",  {31'd0, busy}, 32'd0);
    check("t1_count", {21'd0, word_count}, 32'd2);
    check("t1_nwr",   32'(obs_q.size() - n_base), 32'd2);
    drain();

    // Gapped stream, valid high every third cycle.
    n_base = obs_q.size();
    do_start(11'd1);
    send_word(32'h11223344, 2, 10'd0);
    wait_done(50);
    check("t2_count", {21'd0, word_count}, 32'd1);
    check("t2_nwr",   32'(obs_q.size() - n_base), 32'd1);
    drain();

    // Zero-length load.
    n_base = obs_q.size();
    r_base = rdy_cnt;
    do_start(11'd0);
    check("t3_done_cleared", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("t3_done",  {31'd0, done}, 32'd1);
    check("t3_busy",  {31'd0, busy}, 32'd0);
    check("t3_count", {21'd0, word_count}, 32'd0);
    repeat (2) @(negedge clk);
    check("t3_ready", 32'(rdy_cnt - r_base), 32'd0);
    check("t3_nwr",   32'(obs_q.size() - n_base), 32'd0);

    // Oversized length clamps to the memory capacity.
    n_base = obs_q.size();
    do_start(11'd1500);
    for (int i = 0; i < 1024; i++) begin
      send_word($urandom, 0, 10'(i));
    end
    wait_done(50);
    check("t4_count", {21'd0, word_count}, 32'd1024);
    check("t4_nwr",   32'(obs_q.size() - n_base), 32'd1024);
    last = obs_q[obs_q.size() - 1];
    check("t4_last_addr", {22'd0, last[41:32]}, 32'h3FF);
    drain();

    // Reset in the middle of a word, then reload from scratch.
    n_base = obs_q.size();
    do_start(11'd4);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    check("t5_nwr_abort", 32'(obs_q.size() - n_base), 32'd0);
    do_start(11'd1);
    send_word(32'h01020304, 0, 10'd0);
    wait_done(50);
    check("t5_count", {21'd0, word_count}, 32'd1);
    check("t5_nwr",   32'(obs_q.size() - n_base), 32'd1);
    drain();

    // A start pulse while loading must be ignored.
    n_base = obs_q.size();
    do_start(11'd3);
    send_word(32'hCAFEF00D, 0, 10'd0);
    w1 = 32'h5A5AA5A5;
    send_byte(w1[31:24], 0);
    send_byte(w1[23:16], 0);
    @(negedge clk);
    start     = 1'b1;
    len_words = 11'd1;
    @(negedge clk);
    start     = 1'b0;
    send_byte(w1[15:8], 0);
    send_byte(w1[7:0], 0);
    exp_q.push_back({10'd1, w1});
    send_word(32'h0BADBEEF, 0, 10'd2);
    wait_done(50);
    check("t6_count", {21'd0, word_count}, 32'd3);
    check("t6_nwr",   32'(obs_q.size() - n_base), 32'd3);
    drain();

    check("we_ready_or_idle", 32'(we_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
